ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM (1-cycle read latency, read-before-write) between
//  two requesters, A and B. Each requester has a valid/ready request channel and a response pulse.
//  Ties are broken round-robin. At most one RAM access is issued per cycle.
//  Sits between the Beta memory clients (e.g. instruction fetch = A, data port = B) and the RAM.
// PARAMETERS
//  SIZE   16   word width; must equal the RAM entry width
//  DEPTH  256  number of RAM entries; AW = $clog2(DEPTH)
// PORTS
//  clk            in   1     system clock; all state updates on posedge
//  rst            in   1     asynchronous, active-high reset
//  a_req_valid    in   1     A presents a request
//  a_req_ready    out  1     A's request is accepted this cycle (grant)
//  a_req_write    in   1     1 = write, 0 = read
//  a_req_addr     in   AW    A address
//  a_req_wdata    in   SIZE  A write data
//  a_rsp_valid    out  1     A read data valid this cycle
//  a_rsp_data     out  SIZE  A read data
//  b_*            --   --    identical set of ports for requester B
//  ram_address    out  AW    to RAM address input
//  ram_write_data out  SIZE  to RAM write_data input
//  ram_write_en   out  1     to RAM write_en input
//  ram_read_data  in   SIZE  from RAM read_data output
// BEHAVIOUR
//  - State: rr_last (last granted port, 0 = A, 1 = B); rsp_pend (1b); rsp_port (1b).
//  - Grant (combinational, same cycle):
//    - Only A valid -> A. Only B valid -> B.
//    - Both valid -> the port != rr_last. Neither -> no grant.
//  - x_req_ready = grant_x. A handshake occurs when valid & ready are both high at a posedge.
//    - Requesters must not make valid depend on ready.
//    - Once asserted, valid and its payload must hold until accepted.
//  - RAM drive:
//    - ram_address / ram_write_data are muxed from the granted port.
//    - With no grant, they are driven from port A (don't-care). ram_write_en = grant & req_write.
//  - On every grant, rr_last <= granted port. rr_last is unchanged when there is no grant.
//  - Read accepted at edge N:
//    - rsp_pend <= 1 and rsp_port <= port.
//    - In cycle N+1, x_rsp_valid = 1 for that port only, and x_rsp_data = ram_read_data.
//    - Latency is exactly 1 cycle. There is no response backpressure; the requester must sink it.
//  - Writes produce no response.
//  - Write then read of the same address on the next cycle returns the new data.
//  - rsp_pend is cleared after one cycle unless another read is accepted.
//    - Back-to-back reads give back-to-back responses; throughput is 1 access per cycle.
//  - a_rsp_data and b_rsp_data both carry ram_read_data. Only the matching rsp_valid qualifies it.
//  - Reset (asynchronous, immediate):
//    - rr_last = 1, so A wins the first tie. rsp_pend = 0, rsp_port = 0.
//    - While rst is high: all req_ready = 0, ram_write_en = 0, rsp_valid = 0.
//  - Reset mid-operation: a pending response is dropped and is not replayed after reset.
//    An un-accepted request must be re-presented.
//  - Starvation bound: a continuously valid requester is granted within 2 cycles.
// TESTING
//  1. Reset, then A only: write addr 5 = 0x1234, then read addr 5.
//     -> a_req_ready=1 both cycles; a_rsp_valid=1 one cycle after the read with data 0x1234; b_rsp_valid=0.
//  2. A and B both valid reads for 4 cycles (A addr 1, B addr 2; RAM preloaded 0x0011 / 0x0022).
//     -> grants A,B,A,B; rsp pulses alternate a/b one cycle later with 0x0011 / 0x0022.
//  3. A writes addr 7 = 0xBEEF while B reads addr 7 in the same cycle, after reset.
//     -> A granted first; B granted next cycle; b_rsp_data = 0xBEEF.
//  4. B held valid for 3 cycles, with A requesting only in cycle 2.
//     -> grants B,A,B; rr_last toggles as expected; no cycle has two grants.
//  5. Read accepted, then rst asserted asynchronously mid-cycle before the response.
//     -> rsp_valid stays 0; all ready = 0 during rst; after release, A wins the first tie.
//  6. Neither valid for 10 cycles. -> ram_write_en = 0, no rsp_valid, rr_last unchanged.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// One access per cycle; read responses return exactly one cycle after acceptance.
module ram_port_arbiter #(
    parameter int unsigned SIZE  = 16,
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            a_req_valid,
    output logic            a_req_ready,
    input  logic            a_req_write,
    input  logic [AW-1:0]   a_req_addr,
    input  logic [SIZE-1:0] a_req_wdata,
    output logic            a_rsp_valid,
    output logic [SIZE-1:0] a_rsp_data,

    input  logic            b_req_valid,
    output logic            b_req_ready,
    input  logic            b_req_write,
    input  logic [AW-1:0]   b_req_addr,
    input  logic [SIZE-1:0] b_req_wdata,
    output logic            b_rsp_valid,
    output logic [SIZE-1:0] b_rsp_data,

    output logic [AW-1:0]   ram_address,
    output logic [SIZE-1:0] ram_write_data,
    output logic            ram_write_en,
    input  logic [SIZE-1:0] ram_read_data
);

    logic r_rr_last;
    logic r_rsp_pend;
    logic r_rsp_port;

    logic w_grant_a;
    logic w_grant_b;
    logic w_any_grant;
    logic w_read_accept;
    logic w_grant_write;

    // On a tie the port that was not granted last wins; rst blocks all grants immediately.
    always_comb begin
        w_grant_a = a_req_valid & (~b_req_valid | r_rr_last) & ~rst;
        w_grant_b = b_req_valid & (~a_req_valid | ~r_rr_last) & ~rst;
    end

    always_comb begin
        w_any_grant   = w_grant_a | w_grant_b;
        w_grant_write = w_grant_b ? b_req_write : a_req_write;
        w_read_accept = w_any_grant & ~w_grant_write;
    end

    always_comb begin
        a_req_ready = w_grant_a;
        b_req_ready = w_grant_b;
    end

    // Port A drives the RAM bus when idle; only write_en is qualified.
    always_comb begin
        ram_address    = w_grant_b ? b_req_addr  : a_req_addr;
        ram_write_data = w_grant_b ? b_req_wdata : a_req_wdata;
        ram_write_en   = w_any_grant & w_grant_write;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last  <= 1'b1;
            r_rsp_pend <= 1'b0;
            r_rsp_port <= 1'b0;
        end else begin
            if (w_any_grant) begin
                r_rr_last <= w_grant_b;
            end
            r_rsp_pend <= w_read_accept;
            if (w_read_accept) begin
                r_rsp_port <= w_grant_b;
            end
        end
    end

    always_comb begin
        a_rsp_valid = r_rsp_pend & ~r_rsp_port;
        b_rsp_valid = r_rsp_pend & r_rsp_port;
        a_rsp_data  = ram_read_data;
        b_rsp_data  = ram_read_data;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter with a behavioural RAM and an arbitration/response model.
module tb_ram_port_arbiter;

    localparam int unsigned SIZE  = 16;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;

    logic            clk;
    logic            rst;
    logic            a_req_valid, a_req_ready, a_req_write, a_rsp_valid;
    logic [AW-1:0]   a_req_addr;
    logic [SIZE-1:0] a_req_wdata, a_rsp_data;
    logic            b_req_valid, b_req_ready, b_req_write, b_rsp_valid;
    logic [AW-1:0]   b_req_addr;
    logic [SIZE-1:0] b_req_wdata, b_rsp_data;
    logic [AW-1:0]   ram_address;
    logic [SIZE-1:0] ram_write_data;
    logic            ram_write_en;
    logic [SIZE-1:0] ram_read_data;

    ram_port_arbiter #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .a_req_valid    (a_req_valid),
        .a_req_ready    (a_req_ready),
        .a_req_write    (a_req_write),
        .a_req_addr     (a_req_addr),
        .a_req_wdata    (a_req_wdata),
        .a_rsp_valid    (a_rsp_valid),
        .a_rsp_data     (a_rsp_data),
        .b_req_valid    (b_req_valid),
        .b_req_ready    (b_req_ready),
        .b_req_write    (b_req_write),
        .b_req_addr     (b_req_addr),
        .b_req_wdata    (b_req_wdata),
        .b_rsp_valid    (b_rsp_valid),
        .b_rsp_data     (b_rsp_data),
        .ram_address    (ram_address),
        .ram_write_data (ram_write_data),
        .ram_write_en   (ram_write_en),
        .ram_read_data  (ram_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM: 1-cycle read latency, read-before-write.
    logic [SIZE-1:0] ram_mem [DEPTH];
    logic            preload;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < int'(DEPTH); i++) ram_mem[i] <= 16'(i * 37 + 5);
        end else begin
            ram_read_data <= ram_mem[ram_address];
            if (ram_write_en) ram_mem[ram_address] <= ram_write_data;
        end
    end

    // Reference model state
    logic [SIZE-1:0] m_mem [DEPTH];
    bit              m_rr;
    bit              m_pend;
    bit              m_port;
    logic [SIZE-1:0] m_data;

    int n_checks = 0;
    int n_fail   = 0;
    logic [SIZE-1:0] last_a_rsp, last_b_rsp;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Entered just after a negedge with inputs already driven; leaves at the next negedge.
    task automatic step(output bit ga, output bit gb);
        bit ea, eb;
        logic [AW-1:0] ad;
        #1;
        ea = a_req_valid && (!b_req_valid || m_rr);
        eb = b_req_valid && (!a_req_valid || !m_rr);
        check_eq("a_ready", 32'(a_req_ready), 32'(ea));
        check_eq("b_ready", 32'(b_req_ready), 32'(eb));
        check_eq("ram_we", 32'(ram_write_en),
                 32'((ea && a_req_write) || (eb && b_req_write)));
        if (ea) check_eq("ram_addr_a", 32'(ram_address), 32'(a_req_addr));
        if (eb) check_eq("ram_addr_b", 32'(ram_address), 32'(b_req_addr));
        if (ea && a_req_write) check_eq("ram_wdata_a", 32'(ram_write_data), 32'(a_req_wdata));
        if (eb && b_req_write) check_eq("ram_wdata_b", 32'(ram_write_data), 32'(b_req_wdata));
        @(posedge clk);
        m_pend = 1'b0;
        if (ea || eb) begin
            m_rr = eb;
            ad = eb ? b_req_addr : a_req_addr;
            if (eb ? b_req_write : a_req_write) begin
                m_mem[ad] = eb ? b_req_wdata : a_req_wdata;
            end else begin
                m_pend = 1'b1;
                m_port = eb;
                m_data = m_mem[ad];
            end
        end
        #1;
        check_eq("a_rsp_valid", 32'(a_rsp_valid), 32'(m_pend && !m_port));
        check_eq("b_rsp_valid", 32'(b_rsp_valid), 32'(m_pend && m_port));
        if (m_pend) check_eq("rsp_data", 32'(m_port ? b_rsp_data : a_rsp_data), 32'(m_data));
        if (a_rsp_valid) last_a_rsp = a_rsp_data;
        if (b_rsp_valid) last_b_rsp = b_rsp_data;
        ga = ea;
        gb = eb;
        @(negedge clk);
    endtask

    task automatic drive_a(input logic v, input logic w, input logic [AW-1:0] ad,
                           input logic [SIZE-1:0] d);
        a_req_valid = v; a_req_write = w; a_req_addr = ad; a_req_wdata = d;
    endtask

    task automatic drive_b(input logic v, input logic w, input logic [AW-1:0] ad,
                           input logic [SIZE-1:0] d);
        b_req_valid = v; b_req_write = w; b_req_addr = ad; b_req_wdata = d;
    endtask

    initial begin
        bit ga, gb;
        int wait_a, wait_b;
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 16'(i * 37 + 5);
        m_rr = 1'b1; m_pend = 1'b0; m_port = 1'b0; m_data = '0;
        last_a_rsp = '0; last_b_rsp = '0;
        rst = 1'b1; preload = 1'b1;
        drive_a(1'b1, 1'b1, 8'd0, 16'h0);
        drive_b(1'b1, 1'b1, 8'd0, 16'h0);
        #2;
        check_eq("rst_a_ready", 32'(a_req_ready), 32'd0);
        check_eq("rst_b_ready", 32'(b_req_ready), 32'd0);
        check_eq("rst_ram_we", 32'(ram_write_en), 32'd0);
        check_eq("rst_rsp", 32'({a_rsp_valid, b_rsp_valid}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        preload = 1'b0; rst = 1'b0;
        drive_a(1'b0, 1'b0, 8'd0, 16'h0);
        drive_b(1'b0, 1'b0, 8'd0, 16'h0);

        // A alone: write then read back
        drive_a(1'b1, 1'b1, 8'd5, 16'h1234);
        step(ga, gb);
        drive_a(1'b1, 1'b0, 8'd5, 16'h0);
        step(ga, gb);
        drive_a(1'b0, 1'b0, 8'd0, 16'h0);
        step(ga, gb);
        check_eq("t1_data", 32'(last_a_rsp), 32'h1234);

        // Tied reads alternate A,B,A,B
        drive_a(1'b1, 1'b0, 8'd1, 16'h0);
        drive_b(1'b1, 1'b0, 8'd2, 16'h0);
        for (int i = 0; i < 4; i++) step(ga, gb);
        drive_a(1'b0, 1'b0, 8'd0, 16'h0);
        drive_b(1'b0, 1'b0, 8'd0, 16'h0);

        // Idle: no grants, no writes, arbitration state preserved
        for (int i = 0; i < 10; i++) step(ga, gb);

        // Reset with a read response about to appear
        drive_a(1'b1, 1'b0, 8'd3, 16'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        drive_a(1'b1, 1'b1, 8'd3, 16'h5555);
        drive_b(1'b1, 1'b1, 8'd4, 16'h6666);
        #1;
        check_eq("midrst_rsp", 32'({a_rsp_valid, b_rsp_valid}), 32'd0);
        check_eq("midrst_ready", 32'({a_req_ready, b_req_ready}), 32'd0);
        check_eq("midrst_we", 32'(ram_write_en), 32'd0);
        @(posedge clk);
        #1;
        check_eq("held_rst_rsp", 32'({a_rsp_valid, b_rsp_valid}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_rr = 1'b1; m_pend = 1'b0;
        drive_a(1'b1, 1'b0, 8'd3, 16'h0);
        drive_b(1'b1, 1'b0, 8'd4, 16'h0);
        step(ga, gb);
        check_eq("post_rst_tie_a", 32'(ga), 32'd1);
        drive_a(1'b0, 1'b0, 8'd0, 16'h0);
        drive_b(1'b0, 1'b0, 8'd0, 16'h0);
        step(ga, gb);

        // Randomized traffic; requests hold until accepted
        wait_a = 0; wait_b = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (!a_req_valid && ($urandom_range(3, 0) != 0))
                drive_a(1'b1, 1'($urandom_range(2, 0) == 0), 8'($urandom_range(7, 0)),
                        16'($urandom));
            if (!b_req_valid && ($urandom_range(3, 0) != 0))
                drive_b(1'b1, 1'($urandom_range(2, 0) == 0), 8'($urandom_range(7, 0)),
                        16'($urandom));
            step(ga, gb);
            if (ga) begin a_req_valid = 1'b0; wait_a = 0; end
            else if (a_req_valid) wait_a++;
            if (gb) begin b_req_valid = 1'b0; wait_b = 0; end
            else if (b_req_valid) wait_b++;
            check_eq("starve", 32'((wait_a < 2) && (wait_b < 2)), 32'd1);
        end
        drive_a(1'b0, 1'b0, 8'd0, 16'h0);
        drive_b(1'b0, 1'b0, 8'd0, 16'h0);
        step(ga, gb);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
